// File: rtl/temp_read_sequencer.sv
// temp_read_sequencer: polls an I2C temperature sensor for two bytes and converts the signed MSB to BCD degrees.
module temp_read_sequencer #(
    parameter logic [6:0] SENSOR_ADDR = 7'h4B,
    parameter int unsigned POLL_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_req,
    input  logic        i2c_busy,
    input  logic [7:0]  i2c_data_rd,
    input  logic        i2c_ack_error,
    output logic        i2c_ena,
    output logic [6:0]  i2c_addr,
    output logic        i2c_rw,
    output logic [15:0] temp_raw,
    output logic        temp_neg,
    output logic [3:0]  bcd_hund,
    output logic [3:0]  bcd_tens,
    output logic [3:0]  bcd_ones,
    output logic        temp_valid,
    output logic        ack_err
);
    localparam int CW = $clog2(POLL_CYCLES);
    localparam logic [CW-1:0] POLL_LAST = CW'(POLL_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, BYTE1, WAIT2, BYTE2, CONV, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic          busy_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    msb_q, msb_d, lsb_q, lsb_d, bin_q, bin_d;
    logic [11:0]   bcd_q, bcd_d, dig_q, dig_d, adj;
    logic [2:0]    bit_q, bit_d;
    logic [15:0]   raw_q, raw_d;
    logic          neg_q, neg_d, err_q, err_d;
    logic          rise, fall;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

    assign rise = i2c_busy & ~busy_q;
    assign fall = ~i2c_busy & busy_q;
    assign adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

    assign i2c_addr = SENSOR_ADDR;
    assign i2c_rw = 1'b1;
    assign temp_raw = raw_q;
    assign temp_neg = neg_q;
    assign {bcd_hund, bcd_tens, bcd_ones} = dig_q;
    assign ack_err = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        msb_d = msb_q;
        lsb_d = lsb_q;
        bin_d = bin_q;
        bcd_d = bcd_q;
        bit_d = bit_q;
        raw_d = raw_q;
        neg_d = neg_q;
        dig_d = dig_q;
        err_d = err_q;
        i2c_ena = 1'b0;
        temp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q + 1'b1;
                if (start_req || cnt_q == POLL_LAST) begin
                    state_d = START;
                    cnt_d = '0;
                end
            end
            START: begin
                i2c_ena = 1'b1;
                if (rise) state_d = BYTE1;
            end
            BYTE1: begin
                i2c_ena = 1'b1;
                if (fall) begin
                    msb_d = i2c_data_rd;
                    state_d = i2c_ack_error ? ERR : WAIT2;
                end
            end
            WAIT2: begin
                // dropping ena in the rise cycle makes the master NACK the second byte and STOP
                i2c_ena = ~rise;
                if (rise) state_d = BYTE2;
            end
            BYTE2: begin
                if (fall) begin
                    lsb_d = i2c_data_rd;
                    bin_d = msb_q[7] ? 8'd0 - msb_q : msb_q;
                    bcd_d = '0;
                    bit_d = '0;
                    state_d = i2c_ack_error ? ERR : CONV;
                end
            end
            CONV: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                bit_d = bit_q + 3'd1;
                // results land on the edge into DONE so they are stable while temp_valid is high
                if (bit_q == 3'd7) begin
                    state_d = DONE;
                    raw_d = {msb_q, lsb_q};
                    neg_d = msb_q[7];
                    dig_d = bcd_d;
                    err_d = 1'b0;
                end
            end
            DONE: begin
                temp_valid = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err_d = 1'b1;
                if (!i2c_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
            cnt_q <= '0;
            msb_q <= '0;
            lsb_q <= '0;
            bin_q <= '0;
            bcd_q <= '0;
            bit_q <= '0;
            raw_q <= '0;
            neg_q <= 1'b0;
            dig_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q <= i2c_busy;
            cnt_q <= cnt_d;
            msb_q <= msb_d;
            lsb_q <= lsb_d;
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            bit_q <= bit_d;
            raw_q <= raw_d;
            neg_q <= neg_d;
            dig_q <= dig_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_temp_read_sequencer.sv
// tb_temp_read_sequencer: table-driven and randomized reads against an arithmetic reference model.
module tb_temp_read_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_req = 1'b0;
    logic        i2c_busy = 1'b0;
    logic [7:0]  i2c_data_rd = 8'h00;
    logic        i2c_ack_error = 1'b0;
    logic        i2c_ena;
    logic [6:0]  i2c_addr;
    logic        i2c_rw;
    logic [15:0] temp_raw;
    logic        temp_neg;
    logic [3:0]  bcd_hund, bcd_tens, bcd_ones;
    logic        temp_valid;
    logic        ack_err;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_raw = '0;
    logic        m_neg = 1'b0;
    logic [11:0] m_dig = '0;

    typedef struct {
        logic [7:0]  m, l;
        bit          n1, n2, stray, full;
        logic [15:0] raw;
        bit          neg;
        logic [11:0] dig;
        bit          err;
    } vec_t;

    vec_t tbl[9];

    temp_read_sequencer #(.SENSOR_ADDR(7'h4B), .POLL_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .start_req(start_req),
        .i2c_busy(i2c_busy),
        .i2c_data_rd(i2c_data_rd),
        .i2c_ack_error(i2c_ack_error),
        .i2c_ena(i2c_ena),
        .i2c_addr(i2c_addr),
        .i2c_rw(i2c_rw),
        .temp_raw(temp_raw),
        .temp_neg(temp_neg),
        .bcd_hund(bcd_hund),
        .bcd_tens(bcd_tens),
        .bcd_ones(bcd_ones),
        .temp_valid(temp_valid),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input logic [7:0] m);
        int v, mag;
        v = int'(m);
        mag = (v >= 128) ? 256 - v : v;
        return {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
    endfunction

    task automatic chk_results(input logic [15:0] raw, input bit neg, input logic [11:0] dig, input bit err);
        chk("temp_raw", 32'(temp_raw), 32'(raw));
        chk("temp_neg", 32'(temp_neg), 32'(neg));
        chk("bcd", 32'({bcd_hund, bcd_tens, bcd_ones}), 32'(dig));
        chk("ack_err", 32'(ack_err), 32'(err));
    endtask

    // Plays the I2C master for one read; expected results are passed in by the caller.
    task automatic serve(input vec_t v);
        int t, d1, d2, dw, len;
        bit bad;
        if (!i2c_ena) begin
            @(negedge clk) start_req = 1'b1;
            @(negedge clk) start_req = 1'b0;
        end
        t = 0;
        while (!i2c_ena && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!i2c_ena) begin
            chk("ena_timeout", 32'(i2c_ena), 32'd1);
            return;
        end
        i2c_busy = 1'b1;
        d1 = $urandom_range(2, 4);
        for (int j = 1; j <= d1; j++) begin
            @(negedge clk);
            start_req = (v.stray && j == 1);
        end
        i2c_data_rd = v.m;
        i2c_ack_error = v.n1;
        i2c_busy = 1'b0;
        if (!v.n1) begin
            dw = $urandom_range(1, 3);
            for (int j = 1; j <= dw; j++) begin
                @(negedge clk);
                chk("ena_wait2", 32'(i2c_ena), 32'd1);
                i2c_ack_error = 1'b0;
                i2c_data_rd = 8'($urandom);
            end
            i2c_busy = 1'b1;
            #1;
            chk("ena_drop_on_rise", 32'(i2c_ena), 32'd0);
            d2 = $urandom_range(2, 4);
            for (int j = 1; j <= d2; j++) begin
                @(negedge clk);
                chk("ena_byte2", 32'(i2c_ena), 32'd0);
            end
            i2c_data_rd = v.l;
            i2c_ack_error = v.n2;
            i2c_busy = 1'b0;
        end
        bad = v.n1 || v.n2;
        len = bad ? (v.full ? 12 : 3) : (v.full ? 20 : 10);
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            chk("temp_valid", 32'(temp_valid), 32'(!bad && i == 9));
            chk("ena_idle", 32'(i2c_ena), 32'(v.full && i == len));
            if (bad && i >= 2) chk("ack_err_set", 32'(ack_err), 32'd1);
            if ((!bad && i == 9) || (bad && i == len)) chk_results(v.raw, v.neg, v.dig, v.err);
            i2c_ack_error = 1'b0;
            i2c_data_rd = 8'($urandom);
        end
        m_raw = v.raw;
        m_neg = v.neg;
        m_dig = v.dig;
    endtask

    task automatic check_reset_values();
        chk("rst_ena", 32'(i2c_ena), 32'd0);
        chk("rst_valid", 32'(temp_valid), 32'd0);
        chk_results(16'h0000, 1'b0, 12'h000, 1'b0);
    endtask

    task automatic release_and_poll();
        @(negedge clk) reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("poll_after_reset", 32'(i2c_ena), 32'(i == 10));
        end
        m_raw = '0;
        m_neg = 1'b0;
        m_dig = '0;
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{8'h19, 8'h80, 0, 0, 0, 0, 16'h1980, 0, 12'h025, 0};
        tbl[1] = '{8'h55, 8'h00, 1, 0, 0, 1, 16'h1980, 0, 12'h025, 1};
        tbl[2] = '{8'hF6, 8'h00, 0, 0, 1, 1, 16'hF600, 1, 12'h010, 0};
        tbl[3] = '{8'h80, 8'h00, 0, 0, 0, 0, 16'h8000, 1, 12'h128, 0};
        tbl[4] = '{8'h7F, 8'h12, 0, 1, 0, 0, 16'h8000, 1, 12'h128, 1};
        tbl[5] = '{8'h64, 8'h34, 0, 0, 0, 0, 16'h6434, 0, 12'h100, 0};
        tbl[6] = '{8'hFF, 8'hFF, 0, 0, 0, 0, 16'hFFFF, 1, 12'h001, 0};
        tbl[7] = '{8'h9C, 8'h00, 0, 0, 0, 1, 16'h9C00, 1, 12'h100, 0};
        tbl[8] = '{8'h00, 8'hAB, 0, 0, 0, 0, 16'h00AB, 0, 12'h000, 0};

        repeat (3) @(negedge clk);
        check_reset_values();
        chk("i2c_addr", 32'(i2c_addr), 32'h4B);
        chk("i2c_rw", 32'(i2c_rw), 32'd1);
        release_and_poll();

        for (int k = 0; k < 9; k++) serve(tbl[k]);

        // reset in the middle of the second byte
        if (!i2c_ena) begin
            @(negedge clk) start_req = 1'b1;
            @(negedge clk) start_req = 1'b0;
        end
        i2c_busy = 1'b1;
        repeat (2) @(negedge clk);
        i2c_data_rd = 8'h30;
        i2c_busy = 1'b0;
        repeat (2) @(negedge clk);
        i2c_busy = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk) i2c_busy = 1'b0;
        release_and_poll();
        v = '{8'h19, 8'h80, 0, 0, 0, 1, 16'h1980, 0, 12'h025, 0};
        serve(v);

        for (int k = 0; k < 25; k++) begin
            v.m = 8'($urandom);
            v.l = 8'($urandom);
            v.n1 = ($urandom_range(0, 7) == 0);
            v.n2 = !v.n1 && ($urandom_range(0, 7) == 0);
            v.stray = ($urandom_range(0, 3) == 0);
            v.full = ($urandom_range(0, 1) == 1);
            v.err = v.n1 || v.n2;
            v.raw = v.err ? m_raw : {v.m, v.l};
            v.neg = v.err ? m_neg : v.m[7];
            v.dig = v.err ? m_dig : ref_bcd(v.m);
            serve(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/temp_read_sequencer.md
TEMP_READ_SEQUENCER -- requirements
Module: temp_read_sequencer

Interface
REQ-001 Parameter SENSOR_ADDR, default 7'h4B, 7-bit I2C address of the temperature sensor.
REQ-002 Parameter POLL_CYCLES, default 100_000_000, number of idle clk cycles between automatic reads (min 2).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_req  input  1  one-cycle request for an immediate read; honoured only in IDLE.
REQ-006 i2c_busy  input  1  busy flag from the I2C master.
REQ-007 i2c_data_rd  input  8  byte read by the I2C master; valid on the busy falling edge.
REQ-008 i2c_ack_error  input  1  NACK flag from the I2C master.
REQ-009 i2c_ena  output  1  transaction enable to the I2C master.
REQ-010 i2c_addr  output  7  slave address, constant SENSOR_ADDR.
REQ-011 i2c_rw  output  1  constant 1 (read).
REQ-012 temp_raw  output  16  {MSB, LSB} of the last good read.
REQ-013 temp_neg  output  1  sign of the last good read.
REQ-014 bcd_hund, bcd_tens, bcd_ones  output  4 each  BCD magnitude in integer degrees C.
REQ-015 temp_valid  output  1  one-cycle pulse when new results are valid.
REQ-016 ack_err  output  1  sticky error flag.

Function
REQ-017 The block SHALL detect busy edges from a registered copy of i2c_busy (busy_q): a rise is busy=1 & busy_q=0; a fall is busy=0 & busy_q=1.
REQ-018 States SHALL be IDLE, START, BYTE1, WAIT2, BYTE2, CONV, DONE, ERR.
REQ-019 IDLE: i2c_ena=0; the poll counter increments each cycle; go to START when count = POLL_CYCLES-1 or start_req=1; the counter clears on leaving IDLE.
REQ-020 START: i2c_ena=1; a busy rise moves to BYTE1.
REQ-021 BYTE1: i2c_ena=1; on a busy fall capture i2c_data_rd as MSB and go to WAIT2 (or ERR if i2c_ack_error=1).
REQ-022 WAIT2: i2c_ena=1; a busy rise moves to BYTE2 with i2c_ena=0 from that cycle on, so the master ends with NACK+STOP.
REQ-023 BYTE2: i2c_ena=0; on a busy fall capture LSB and go to CONV (or ERR if i2c_ack_error=1).
REQ-024 Sign and magnitude: temp_neg = MSB[7]; magnitude = MSB if positive, else two's-complement negation of MSB as 8-bit unsigned (0x80 -> 128); LSB does not affect BCD.
REQ-025 CONV SHALL run a shift-add-3 binary-to-BCD conversion, one bit per cycle, for exactly 8 cycles, then go to DONE.
REQ-026 DONE SHALL update temp_raw, temp_neg and the BCD outputs together, pulse temp_valid for 1 cycle, clear ack_err, and return to IDLE.
REQ-027 Latency: if the BYTE2 busy fall is detected in cycle N, temp_valid SHALL be high in cycle N+9 only.
REQ-028 Result outputs SHALL change only in DONE; an intermediate or failed read never alters them.
REQ-029 ERR: i2c_ena=0; set ack_err; wait for i2c_busy=0, then go to IDLE; results are unchanged.
REQ-030 start_req outside IDLE SHALL be ignored, not queued.
REQ-031 The simultaneous start_req and poll-count match SHALL cause a single START.

Reset
REQ-032 While reset=1: state=IDLE, poll counter=0, busy_q=0, i2c_ena=0, temp_raw=0, temp_neg=0, BCD digits=0, temp_valid=0, ack_err=0.
REQ-033 Reset mid-transaction SHALL take effect immediately, deassert i2c_ena, and discard partial bytes.
REQ-034 After release, the first automatic read SHALL start POLL_CYCLES cycles later unless start_req occurs first.

Verification
REQ-035 start_req, master model returns 0x19 then 0x80 -> temp_raw=16'h1980, temp_neg=0, BCD 0/2/5, temp_valid 1 cycle at N+9.
REQ-036 Bytes 0xF6, 0x00 -> temp_neg=1, BCD 0/1/0; bytes 0x80, 0x00 -> temp_neg=1, BCD 1/2/8.
REQ-037 NACK on BYTE1 -> ack_err=1, i2c_ena=0, no temp_valid, previous 25 C result held; next good read clears ack_err.
REQ-038 POLL_CYCLES=10, no start_req -> i2c_ena rises 10 cycles after reset release, then 10 idle cycles after each DONE or ERR.
REQ-039 Assert reset during BYTE2 -> all outputs return to reset values asynchronously; the next read completes normally.
REQ-040 start_req pulsed during BYTE1 -> exactly one transaction occurs and one temp_valid pulse.
